// File: rtl/bdd_node_store_ctrl.sv
// Node SRAM requester: sequential slot allocation on port A,
// latency-timed lookups on port B with a valid/ready response.
module bdd_node_store_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 34,
   parameter int DEPTH      = 8,
   parameter int RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_done,
   output logic [ADDR_WIDTH-1:0] wr_idx,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] sram_data_a,
   output logic [ADDR_WIDTH-1:0] sram_addr_a,
   output logic                  sram_we_a,
   output logic [ADDR_WIDTH-1:0] sram_addr_b,
   input  logic [DATA_WIDTH-1:0] sram_q_b
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } rd_state_e;

   // Slots are allocated strictly in order, so the count doubles as the write pointer.
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_a_q;
   logic [DATA_WIDTH-1:0] data_a_q;
   logic                  wr_acc;

   rd_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
   logic [LW-1:0]         lat_q, lat_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;

   assign full     = (cnt_q == DEPTH_C);
   assign wr_ready = !full && !clr;
   assign wr_acc   = wr_valid && wr_ready;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (wr_acc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         we_q     <= 1'b0;
         addr_a_q <= '0;
         data_a_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         we_q  <= wr_acc;
         if (wr_acc) begin
            addr_a_q <= cnt_q[ADDR_WIDTH-1:0];
            data_a_q <= wr_data;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_b_d   = addr_b_q;
      lat_d      = lat_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (rd_valid) begin
               if ({1'b0, rd_addr} >= cnt_q) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
                  state_d    = S_RESP;
               end else begin
                  addr_b_d = rd_addr;
                  lat_d    = LAT_LOAD;
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               rsp_data_d = sram_q_b;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_b_q   <= '0;
         lat_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_b_q   <= addr_b_d;
         lat_q      <= lat_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign rd_ready    = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign count       = cnt_q;
   assign wr_done     = we_q;
   assign wr_idx      = addr_a_q;
   assign sram_we_a   = we_q;
   assign sram_addr_a = addr_a_q;
   assign sram_data_a = data_a_q;
   assign sram_addr_b = addr_b_q;

endmodule

// File: tb/tb_bdd_node_store_ctrl.sv
// Bench for bdd_node_store_ctrl: behavioural SRAM with a one-cycle
// registered read, fill table, scoreboarded inserts and lookups.
module tb_bdd_node_store_ctrl;

   localparam int AW     = 3;
   localparam int DW     = 34;
   localparam int DEPTH  = 8;
   localparam int RD_LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          wr_done;
   logic [AW-1:0] wr_idx;
   logic          rd_valid = 1'b0;
   logic          rd_ready;
   logic [AW-1:0] rd_addr = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [AW:0]   count;
   logic          full;
   logic [DW-1:0] sram_data_a;
   logic [AW-1:0] sram_addr_a;
   logic          sram_we_a;
   logic [AW-1:0] sram_addr_b;
   logic [DW-1:0] sram_q_b = '0;

   logic [DW-1:0] mem [DEPTH];

   bdd_node_store_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .wr_done(wr_done), .wr_idx(wr_idx),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .count(count), .full(full),
      .sram_data_a(sram_data_a), .sram_addr_a(sram_addr_a),
      .sram_we_a(sram_we_a), .sram_addr_b(sram_addr_b),
      .sram_q_b(sram_q_b)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   always @(posedge clk) begin
      if (sram_we_a) mem[sram_addr_a] <= sram_data_a;
      sram_q_b <= mem[sram_addr_b];
   end

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;

   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
   } wr_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } rd_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          exp_ready;
      logic [AW:0]   exp_cnt;
   } fill_vec_t;

   wr_exp_t wq[$];
   rd_exp_t rq[$];
   wr_exp_t we_e;
   rd_exp_t re_e;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (sram_we_a) we_cnt++;
         if (wr_done) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_done_unexpected got idx %0d want none", wr_idx);
            end else begin
               we_e = wq.pop_front();
               chk("wr_idx", {61'd0, wr_idx}, {61'd0, we_e.idx});
               chk("sram_addr_a", {61'd0, sram_addr_a}, {61'd0, we_e.idx});
               chk("sram_data_a", {30'd0, sram_data_a}, {30'd0, we_e.data});
               chk("sram_we_a", {63'd0, sram_we_a}, 64'd1);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected got %0h want none", rsp_data);
            end else begin
               re_e = rq.pop_front();
               chk("rsp_data", {30'd0, rsp_data}, {30'd0, re_e.data});
               chk("rsp_err", {63'd0, rsp_err}, {63'd0, re_e.err});
            end
         end
      end
   end

   task automatic insert(input logic [AW-1:0] idx, input logic [DW-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      wq.push_back('{idx: idx, data: d});
      step();
      wr_valid = 1'b0;
   endtask

   // Starts and ends at posedge+1; optional same-cycle insert.
   task automatic lookup(input string nm, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic e,
                         input int exp_lat, input int hold,
                         input logic ins, input logic [DW-1:0] ins_d);
      logic [AW-1:0] b0;
      int n;
      b0 = sram_addr_b;
      rd_valid = 1'b1;
      rd_addr  = a;
      if (ins) begin
         wr_valid = 1'b1;
         wr_data  = ins_d;
         wq.push_back('{idx: a, data: ins_d});
      end
      @(negedge clk);
      chk({nm, "_rd_ready"}, {63'd0, rd_ready}, 64'd1);
      rq.push_back('{data: d, err: e});
      step();
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!rsp_valid) chk({nm, "_busy"}, {63'd0, rd_ready}, 64'd0);
      end while (!rsp_valid && n < 20);
      chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
      if (e) chk({nm, "_addr_b"}, {61'd0, sram_addr_b}, {61'd0, b0});
      for (int h = 0; h < hold; h++) begin
         step();
         @(negedge clk);
         chk({nm, "_hold_v"}, {63'd0, rsp_valid}, 64'd1);
         chk({nm, "_hold_d"}, {30'd0, rsp_data}, {30'd0, d});
         chk({nm, "_hold_e"}, {63'd0, rsp_err}, {63'd0, e});
         chk({nm, "_hold_rdy"}, {63'd0, rd_ready}, 64'd0);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      step();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_idle"}, {62'd0, rd_ready, rsp_valid}, 64'd2);
      step();
   endtask

   fill_vec_t fv [9];

   initial begin
      for (int i = 0; i < 8; i++) begin
         fv[i].data      = DW'((i + 1) * 'h11);
         fv[i].exp_ready = 1'b1;
         fv[i].exp_cnt   = (AW + 1)'(i);
      end
      fv[8].data      = DW'('h99);
      fv[8].exp_ready = 1'b0;
      fv[8].exp_cnt   = (AW + 1)'(8);

      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
      chk("rst_rd_ready", {63'd0, rd_ready}, 64'd1);
      chk("rst_count", {60'd0, count}, 64'd0);
      chk("rst_full", {63'd0, full}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_we_a", {62'd0, sram_we_a, wr_done}, 64'd0);
      step();

      we_cnt   = 0;
      for (int i = 0; i < 9; i++) begin
         wr_valid = 1'b1;
         wr_data  = fv[i].data;
         @(negedge clk);
         chk("fill_wr_ready", {63'd0, wr_ready}, {63'd0, fv[i].exp_ready});
         chk("fill_count", {60'd0, count}, {60'd0, fv[i].exp_cnt});
         if (fv[i].exp_ready) wq.push_back('{idx: AW'(i), data: fv[i].data});
         step();
      end
      wr_valid = 1'b0;
      @(negedge clk);
      chk("full_count", {60'd0, count}, 64'd8);
      chk("full_flag", {63'd0, full}, 64'd1);
      chk("full_wr_ready", {63'd0, wr_ready}, 64'd0);
      chk("fill_we_cycles", 64'(we_cnt), 64'd8);
      step();

      lookup("lk3", 3'd3, DW'('h44), 1'b0, RD_LAT + 1, 5, 1'b0, '0);
      lookup("lk7", 3'd7, DW'('h88), 1'b0, RD_LAT + 1, 0, 1'b0, '0);

      clr      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = DW'('h99);
      @(negedge clk);
      chk("clr_wr_ready", {63'd0, wr_ready}, 64'd0);
      step();
      clr      = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      chk("clr_count", {60'd0, count}, 64'd0);
      chk("clr_full", {63'd0, full}, 64'd0);
      step();

      insert(3'd0, DW'('hAA));
      clr = 1'b1;
      step();
      clr = 1'b0;
      @(negedge clk);
      chk("clr_pending_count", {60'd0, count}, 64'd0);
      step();

      insert(3'd0, DW'('hCC));
      insert(3'd1, DW'('hBB));
      @(negedge clk);
      chk("refill_count", {60'd0, count}, 64'd2);
      step();

      lookup("lk5err", 3'd5, '0, 1'b1, 1, 2, 1'b0, '0);
      lookup("lk0", 3'd0, DW'('hCC), 1'b0, RD_LAT + 1, 0, 1'b0, '0);
      lookup("lksame", 3'd2, '0, 1'b1, 1, 0, 1'b1, DW'('hDD));
      lookup("lk2", 3'd2, DW'('hDD), 1'b0, RD_LAT + 1, 0, 1'b0, '0);

      rd_valid = 1'b1;
      rd_addr  = 3'd1;
      step();
      rd_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rstwait_idle", {62'd0, rsp_valid, rd_ready}, 64'd1);
         step();
      end
      @(negedge clk);
      chk("rstwait_count", {60'd0, count}, 64'd0);
      chk("wq_empty", 64'(wq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bdd_node_store_ctrl.md
Name: bdd_node_store_ctrl

Overview:
Requester-side controller that drives the dual-port node SRAM in the BDD accelerator: write port A (data_a/addr_a/we_a) and read port B (addr_b/q_b).
Accepts node-insert requests, allocates SRAM slots sequentially and returns the allocated index.
Serves node-lookup requests through an FSM that drives addr_b, waits the read latency, captures q_b and holds a response under valid/ready.
Sits between the BDD traversal/unique-table logic and the node SRAM.

Parameters:
ADDR_WIDTH, 3, SRAM address width
DATA_WIDTH, 34, node word width
DEPTH, 8, number of SRAM entries (must be <= 2**ADDR_WIDTH)
RD_LAT, 2, cycles addr_b is held before q_b is sampled (>= 1)

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
clr  input  1  pulse: free all slots (pointer/count to 0, memory untouched)
wr_valid  input  1  insert request valid
wr_ready  output  1  insert request ready
wr_data  input  DATA_WIDTH  node word to insert
wr_done  output  1  one-cycle pulse: insert committed to SRAM
wr_idx  output  ADDR_WIDTH  index allocated to the committed insert
rd_valid  input  1  lookup request valid
rd_ready  output  1  lookup request ready
rd_addr  input  ADDR_WIDTH  index to look up
rsp_valid  output  1  lookup response valid
rsp_ready  input  1  lookup response accepted
rsp_data  output  DATA_WIDTH  node word read
rsp_err  output  1  lookup index was not allocated
count  output  ADDR_WIDTH+1  allocated slots
full  output  1  count == DEPTH
sram_data_a  output  DATA_WIDTH  to SRAM data_a
sram_addr_a  output  ADDR_WIDTH  to SRAM addr_a
sram_we_a  output  1  to SRAM we_a
sram_addr_b  output  ADDR_WIDTH  to SRAM addr_b
sram_q_b  input  DATA_WIDTH  from SRAM q_b

Behaviour:
- Reset (rst_n low at posedge): all outputs 0 except rd_ready=1 and wr_ready=1. The pointer, count and read FSM go to 0/IDLE, and any in-flight lookup is dropped with no response.
- wr_ready = !full && !clr, combinational. An insert is accepted when wr_valid && wr_ready.
- Accept cycle T:
  - wr_ptr and count increment at the T edge.
  - At T+1: sram_addr_a = old wr_ptr, sram_data_a = wr_data, sram_we_a = 1 for exactly one cycle, wr_done = 1, wr_idx = old wr_ptr.
  - Back-to-back inserts give a continuous we_a with incrementing addresses.
- Pointer: increments and saturates at DEPTH (no wrap). full blocks further inserts until clr or reset.
- clr: at the next edge, count = 0 and wr_ptr = 0. A write already registered for T+1 still completes. clr has priority over a same-cycle insert (the insert is not accepted). clr does not affect the read FSM.
- Read FSM states: IDLE, WAIT, RESP.
  - IDLE: rd_ready = 1. On rd_valid:
    - If rd_addr >= count (value before this cycle's update): go to RESP with rsp_err = 1, rsp_data = 0 and no SRAM access.
    - Otherwise: sram_addr_b <= rd_addr, a latency counter is loaded, go to WAIT.
  - WAIT: rd_ready = 0. After sram_addr_b has been stable for RD_LAT cycles, register rsp_data <= sram_q_b, rsp_err = 0, go to RESP.
  - RESP: rsp_valid = 1; rsp_data and rsp_err stay stable until rsp_ready. On rsp_ready, go to IDLE.
  - Next-request latency: a new request can be accepted the cycle after the handshake (rd_ready = 1 in IDLE).
- Valid-lookup latency: accept at T, then rsp_valid at T+RD_LAT+1.
- sram_addr_b holds its last value outside WAIT.
- Insert and lookup for the same index in the same cycle: the lookup sees the pre-update count and returns rsp_err = 1.
- A lookup accepted after an insert's accept cycle returns the new data. This is guaranteed because we_a lands at T+1 and sampling happens no earlier than RD_LAT >= 1 cycles later.
- Ports A and B operate independently; inserts are never stalled by lookups.

Test Plan:
1. Reset -> wr_ready = 1, rd_ready = 1, count = 0, full = 0, rsp_valid = 0, sram_we_a = 0.
2. Insert 0x0_0000_0011 ... 0x0_0000_0088 back-to-back -> wr_idx 0..7 with wr_done pulses, sram_we_a high for 8 cycles, count = 8, full = 1, wr_ready = 0. A 9th wr_valid is held and not accepted.
3. After fill, lookup rd_addr = 3 -> rsp_valid at accept+3 (RD_LAT = 2), rsp_data = 0x0_0000_0044, rsp_err = 0.
4. count = 2, lookup rd_addr = 5 -> rsp_err = 1, rsp_data = 0, sram_addr_b unchanged.
5. rsp_ready held low 5 cycles during a response -> rsp_valid, rsp_data and rsp_err stable, rd_ready = 0. The handshake then returns to IDLE.
6. clr asserted with wr_valid at full -> insert not accepted, count = 0. The next insert gets wr_idx = 0. rst_n pulled low in WAIT -> no rsp_valid afterwards, FSM in IDLE.
